// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: N-digit multiplexed 7-segment display scanner.
// Snapshots a packed nibble vector on load and scans one digit per refresh
// period. Each digit gets hex/BCD decode, decimal point, leading-zero
// blanking and a global enable. All outputs are registered.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous reset, active-high
//   value     packed nibbles, digit i = value[4i+3:4i], digit 0 rightmost
//   dp        decimal point request per digit
//   load      capture value/dp into the shadow registers on this edge
//   blank_lz  suppress leading zeros (digit 0 never blanked)
//   en        0 turns the display off; scanning keeps running
//   SSeg      segments {a,b,c,d,e,f,g}
//   dp_out    decimal point segment
//   an        one-hot anode select, an[i] drives digit i
module seg7_scan_driver #(
  parameter int unsigned N_DIGITS    = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned HEX_EN      = 1,
  parameter int unsigned ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic                  en,
  output logic [6:0]            SSeg,
  output logic                  dp_out,
  output logic [N_DIGITS-1:0]   an
);

  localparam int unsigned VAL_W = 4 * N_DIGITS;
  localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = $clog2(N_DIGITS);
  localparam logic        INV   = (ACTIVE_LOW != 0);
  localparam logic        HEX   = (HEX_EN != 0);

  logic [VAL_W-1:0]    shadow;
  logic [N_DIGITS-1:0] dp_sh;
  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic                tick;

  logic [N_DIGITS-1:0] lead_zero;
  logic [N_DIGITS-1:0] an_sel;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_lz;
  logic                slot_on;
  logic [6:0]          seg_nx;
  logic                dp_nx;
  logic [N_DIGITS-1:0] an_nx;

  // Hex/BCD decode, internal polarity (1 = lit), order abcdefg
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1111110;
      4'h1:    seg = 7'b0110000;
      4'h2:    seg = 7'b1101101;
      4'h3:    seg = 7'b1111001;
      4'h4:    seg = 7'b0110011;
      4'h5:    seg = 7'b1011011;
      4'h6:    seg = 7'b1011111;
      4'h7:    seg = 7'b1110000;
      4'h8:    seg = 7'b1111111;
      4'h9:    seg = 7'b1111011;
      4'hA:    seg = 7'b1110111;
      4'hB:    seg = 7'b0011111;
      4'hC:    seg = 7'b1001110;
      4'hD:    seg = 7'b0111101;
      4'hE:    seg = 7'b1001111;
      default: seg = 7'b1000111;
    endcase
    if (!HEX && (nib > 4'd9)) seg = 7'b0000001;
    return seg;
  endfunction

  assign tick = (cnt == CNT_W'(REFRESH_DIV - 1));

  // Slot selection, leading-zero detection and next output values
  always_comb begin
    logic run;
    lead_zero = '0;
    an_sel    = '0;
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_lz    = 1'b0;
    run       = 1'b1;
    // lead_zero[i]: digits N-1..i are all zero
    for (int i = int'(N_DIGITS) - 1; i >= 0; i--) begin
      run          = run && (shadow[4*i +: 4] == 4'd0);
      lead_zero[i] = run;
    end
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib   = shadow[4*i +: 4];
        cur_dp    = dp_sh[i];
        cur_lz    = lead_zero[i];
        an_sel[i] = 1'b1;
      end
    end
    slot_on = en && !(blank_lz && (idx != '0) && cur_lz);
    seg_nx  = slot_on ? decode(cur_nib) : 7'b0000000;
    dp_nx   = slot_on && cur_dp;
    an_nx   = slot_on ? an_sel : '0;
  end

  // Shadow registers, refresh counter and digit index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
      dp_sh  <= '0;
      cnt    <= '0;
      idx    <= '0;
    end else begin
      if (load) begin
        shadow <= value;
        dp_sh  <= dp;
      end
      cnt <= tick ? '0 : cnt + CNT_W'(1);
      if (tick) idx <= (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end
  end

  // Output registers; polarity applied at the register input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      SSeg   <= {7{INV}};
      dp_out <= INV;
      an     <= {N_DIGITS{INV}};
    end else begin
      SSeg   <= seg_nx ^ {7{INV}};
      dp_out <= dp_nx ^ INV;
      an     <= an_nx ^ {N_DIGITS{INV}};
    end
  end

endmodule
